// File: rtl/requantize_sat_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// requantize_sat_pkg : sample/accumulator format constants for the IIR datapath
// Revision 1.0
// ---------------------------------------------------------------------------
package requantize_sat_pkg;

  localparam int FRAC_DEF = 16;
  localparam int INT_DEF  = 12;

  function automatic int sample_width(input int frac, input int intb);
    return frac + intb + 1;
  endfunction

  function automatic int acc_width(input int frac, input int intb);
    return 2 * (frac + intb) + 1;
  endfunction

  localparam int SW_DEF = sample_width(FRAC_DEF, INT_DEF);
  localparam int AW_DEF = acc_width(FRAC_DEF, INT_DEF);

  localparam logic [SW_DEF-1:0] SAMPLE_MAX = {1'b0, {(SW_DEF-1){1'b1}}};
  localparam logic [SW_DEF-1:0] SAMPLE_MIN = {1'b1, {(SW_DEF-1){1'b0}}};

endpackage
`default_nettype wire

// File: rtl/requantize_sat_round_sat.sv
`default_nettype none
// ---------------------------------------------------------------------------
// requantize_sat_round_sat : clip a shifted signed value into an SW-bit sample
// Revision 1.0
// ---------------------------------------------------------------------------
module requantize_sat_round_sat
  import requantize_sat_pkg::*;
#(
  parameter int IW = AW_DEF + 1 - FRAC_DEF,
  parameter int SW = SW_DEF
) (
  input  logic [IW-1:0] val_in,
  output logic [SW-1:0] val_out,
  output logic          sat
);

  localparam logic [SW-1:0] POS_LIMIT = {1'b0, {(SW-1){1'b1}}};
  localparam logic [SW-1:0] NEG_LIMIT = {1'b1, {(SW-1){1'b0}}};

  logic fits;

  // The value fits when every bit above the sample sign bit repeats the sign.
  always_comb begin
    fits = (val_in[IW-1:SW-1] == {(IW-SW+1){val_in[IW-1]}});
    sat  = ~fits;
    if (fits) begin
      val_out = val_in[SW-1:0];
    end else if (val_in[IW-1]) begin
      val_out = NEG_LIMIT;
    end else begin
      val_out = POS_LIMIT;
    end
  end

endmodule
`default_nettype wire

// File: rtl/requantize_sat.sv
`default_nettype none
// ---------------------------------------------------------------------------
// requantize_sat : round-half-up + saturate accumulator to sample, 2-stage pipe
// Optional saturation counter/sticky enabled by macro SAT_COUNT_EN. Rev 1.0
// ---------------------------------------------------------------------------
module requantize_sat
  import requantize_sat_pkg::*;
#(
  parameter int FRAC = FRAC_DEF,
  parameter int INT  = INT_DEF
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [2*(FRAC+INT):0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [FRAC+INT:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sat,
  input  logic                    sat_clr,
  output logic [15:0]             sat_count,
  output logic                    sat_sticky
);

  localparam int SW  = FRAC + INT + 1;
  localparam int AW  = 2 * (FRAC + INT) + 1;
  localparam int S1W = AW + 1 - FRAC;

  logic           en;
  logic [S1W-1:0] s1_q, s1_d;
  logic           s1_valid_q, s1_valid_d;
  logic [SW-1:0]  out_data_q, out_data_d;
  logic           out_sat_q, out_sat_d;
  logic           out_valid_q, out_valid_d;
  logic [SW-1:0]  rs_data;
  logic           rs_sat;
  logic [FRAC-2:0] unused_frac_lsbs;

  // Adding half an LSB only carries into the kept bits when bit FRAC-1 is set,
  // so the lower fraction bits never influence the result.
  assign unused_frac_lsbs = in_data[FRAC-2:0];

  always_comb begin
    en          = ~out_valid_q | out_ready;
    s1_d        = s1_q;
    s1_valid_d  = s1_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;
    if (en) begin
      s1_d        = {in_data[AW-1], in_data[AW-1:FRAC]}
                  + {{(S1W-1){1'b0}}, in_data[FRAC-1]};
      s1_valid_d  = in_valid;
      out_data_d  = rs_data;
      out_sat_d   = rs_sat;
      out_valid_d = s1_valid_q;
    end
  end

  requantize_sat_round_sat #(
    .IW (S1W),
    .SW (SW)
  ) u_round_sat (
    .val_in  (s1_q),
    .val_out (rs_data),
    .sat     (rs_sat)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s1_valid_q  <= s1_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = en;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_valid = out_valid_q;

`ifdef SAT_COUNT_EN
  logic [15:0] sat_count_q, sat_count_d;
  logic        sat_sticky_q, sat_sticky_d;

  // Clear takes priority over a saturating transfer in the same cycle.
  always_comb begin
    sat_count_d  = sat_count_q;
    sat_sticky_d = sat_sticky_q;
    if (sat_clr) begin
      sat_count_d  = '0;
      sat_sticky_d = 1'b0;
    end else if (out_valid_q & out_ready & out_sat_q) begin
      sat_sticky_d = 1'b1;
      if (sat_count_q != 16'hFFFF) begin
        sat_count_d = sat_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sat_count_q  <= '0;
      sat_sticky_q <= 1'b0;
    end else begin
      sat_count_q  <= sat_count_d;
      sat_sticky_q <= sat_sticky_d;
    end
  end

  assign sat_count  = sat_count_q;
  assign sat_sticky = sat_sticky_q;
`else
  logic unused_sat_clr;

  assign unused_sat_clr = sat_clr;
  assign sat_count      = '0;
  assign sat_sticky     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_requantize_sat.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_requantize_sat : directed + randomized bench with arithmetic reference model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_requantize_sat;

  typedef struct packed {
    logic [28:0] data;
    logic        sat;
  } exp_t;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [56:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [28:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sat;
  logic        sat_clr;
  logic [15:0] sat_count;
  logic        sat_sticky;

  always #5 aclk = ~aclk;

  requantize_sat dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sat    (out_sat),
    .sat_clr    (sat_clr),
    .sat_count  (sat_count),
    .sat_sticky (sat_sticky)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];
  logic m_s1v, m_ov;
  logic [15:0] m_cnt;
  logic m_sticky;

  // Expected sample: floor(v/2^16 + 1/2), then clip to the Q12.16 range.
  function automatic exp_t ref_model(input logic [56:0] d);
    longint v, q;
    exp_t   e;
    v = $signed(d);
    q = (v + 64'sd32768) >>> 16;
    if (q > 64'sd268435455) begin
      e.data = 29'h0FFFFFFF; e.sat = 1'b1;
    end else if (q < -64'sd268435456) begin
      e.data = 29'h10000000; e.sat = 1'b1;
    end else begin
      e.data = q[28:0]; e.sat = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [56:0] rand_acc();
    longint x;
    x = {$urandom, $urandom};
    case ($urandom_range(0, 2))
      0:       x = x;
      1:       x = x >>> 19;
      default: x = ((x >>> 35) <<< 16) | 64'h8000;
    endcase
    return x[56:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check outputs against the model, advance the model.
  task automatic cycle(input logic v, input logic [56:0] d, input logic rdy,
                       input logic clr, input exp_t ex, output logic acc);
    logic en;
    exp_t e;
    in_valid = v; in_data = d; out_ready = rdy; sat_clr = clr;
    #1;
    en = !m_ov || rdy;
    check("in_ready", {63'd0, in_ready}, {63'd0, en});
    check("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
    check("sat_count", {48'd0, sat_count}, {48'd0, m_cnt});
    check("sat_sticky", {63'd0, sat_sticky}, {63'd0, m_sticky});
    if (m_ov && rdy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $error("FAIL unexpected_output observed=%0h expected=none", out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_data", {35'd0, out_data}, {35'd0, e.data});
        check("out_sat", {63'd0, out_sat}, {63'd0, e.sat});
`ifdef SAT_COUNT_EN
        if (!clr && e.sat) begin
          if (m_cnt != 16'hFFFF) m_cnt++;
          m_sticky = 1'b1;
        end
`endif
      end
    end
`ifdef SAT_COUNT_EN
    if (clr) begin
      m_cnt = '0; m_sticky = 1'b0;
    end
`endif
    acc = v && en;
    if (acc) exp_q.push_back(ex);
    @(posedge aclk);
    if (en) begin
      m_ov  = m_s1v;
      m_s1v = v;
    end
    #1;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0, '0, a);
  endtask

  task automatic drain(input logic random_ready);
    logic a;
    int   budget;
    budget = 100;
    while ((exp_q.size() != 0 || m_ov || m_s1v) && budget > 0) begin
      cycle(1'b0, '0, random_ready ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, '0, a);
      budget--;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  longint      dir_in [10] = '{64'h1_8000_0000, 64'h8000, 64'h7FFF, -64'sh8000, -64'sh8001,
                               64'sd1 <<< 44, -(64'sd1 <<< 44), -(64'sd1 <<< 44) - (64'sd1 <<< 32),
                               (64'sd1 <<< 56) - 1, -(64'sd1 <<< 56)};
  logic [28:0] dir_out[10] = '{29'h18000, 29'h1, 29'h0, 29'h0, 29'h1FFFFFFF,
                               29'h0FFFFFFF, 29'h10000000, 29'h10000000, 29'h0FFFFFFF, 29'h10000000};
  logic        dir_sat[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    logic        acc;
    logic [56:0] d;
    longint      lv;
    exp_t        ex;
    logic [56:0] burst[8];
    int          idx, budget;

    aresetn = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; sat_clr = 1'b0;
    m_s1v = 1'b0; m_ov = 1'b0; m_cnt = '0; m_sticky = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {35'd0, out_data}, 64'd0);
    check("rst_out_sat", {63'd0, out_sat}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_sat_count", {48'd0, sat_count}, 64'd0);
    check("rst_sat_sticky", {63'd0, sat_sticky}, 64'd0);
    aresetn = 1'b1;

    // Directed values, each followed by idles so the 2-cycle latency is exact.
    for (int i = 0; i < 10; i++) begin
      lv = dir_in[i]; d = lv[56:0];
      ex.data = dir_out[i]; ex.sat = dir_sat[i];
      cycle(1'b1, d, 1'b1, 1'b0, ex, acc);
      idle(2);
    end
    drain(1'b0);

    // Burst of 8 with random backpressure; input held until accepted.
    for (int i = 0; i < 8; i++) burst[i] = rand_acc();
    idx = 0; budget = 200;
    while (idx < 8 && budget > 0) begin
      cycle(1'b1, burst[idx], 1'($urandom_range(0, 1)), 1'b0, ref_model(burst[idx]), acc);
      if (acc) idx++;
      budget--;
    end
    check("burst_all_accepted", 64'(idx), 64'd8);
    drain(1'b1);

    // Longer random run with random valid, ready and clear.
    for (int i = 0; i < 120; i++) begin
      d = rand_acc();
      cycle(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), ref_model(d), acc);
    end
    drain(1'b1);

    // Saturation counter: three saturating transfers.
    cycle(1'b0, '0, 1'b1, 1'b1, '0, acc);
    lv = 64'sd1 <<< 44; d = lv[56:0];
    for (int i = 0; i < 3; i++) cycle(1'b1, d, 1'b1, 1'b0, ref_model(d), acc);
    idle(3);
`ifdef SAT_COUNT_EN
    check("sat_count_after3", {48'd0, sat_count}, 64'd3);
    check("sat_sticky_after3", {63'd0, sat_sticky}, 64'd1);
`else
    check("sat_count_tied0", {48'd0, sat_count}, 64'd0);
    check("sat_sticky_tied0", {63'd0, sat_sticky}, 64'd0);
`endif
    // Clear in the same cycle as a saturating output transfer.
    cycle(1'b1, d, 1'b1, 1'b0, ref_model(d), acc);
    idle(1);
    cycle(1'b0, '0, 1'b1, 1'b1, '0, acc);
    idle(1);
    check("sat_count_cleared", {48'd0, sat_count}, 64'd0);
    check("sat_sticky_cleared", {63'd0, sat_sticky}, 64'd0);

    // Reset with two samples in flight.
    lv = 64'h1_8000_0000; d = lv[56:0];
    cycle(1'b1, d, 1'b1, 1'b0, ref_model(d), acc);
    cycle(1'b1, d, 1'b1, 1'b0, ref_model(d), acc);
    aresetn = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_out_data", {35'd0, out_data}, 64'd0);
    exp_q.delete();
    m_s1v = 1'b0; m_ov = 1'b0; m_cnt = '0; m_sticky = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    lv = 64'h8000; d = lv[56:0];
    ex.data = 29'h1; ex.sat = 1'b0;
    cycle(1'b1, d, 1'b1, 1'b0, ex, acc);
    idle(3);
    check("post_rst_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
